// File: rtl/cordic_dir_relay.sv
`default_nettype none
// ============================================================================
// Module   : cordic_dir_relay
// Purpose  : Captures the per-iteration direction bits of a vectoring CORDIC,
//            queues each complete angle word, and replays a queued word bit by
//            bit into a rotation CORDIC together with its start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_dir_relay #(
  parameter int CORDIC_NUM = 14,
  parameter int AW         = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vec_start_i,
  input  logic          vec_d_i,
  input  logic          rot_req_i,
  input  logic          rot_pop_i,
  output logic          rot_start_o,
  output logic          rot_d_o,
  output logic          rot_busy_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          cap_err_o
);

  localparam int DEPTH = 1 << AW;
  localparam int CNTW  = AW + 1;
  localparam int CW    = (CORDIC_NUM > 1) ? $clog2(CORDIC_NUM) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(CORDIC_NUM - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [0:0] {CIDLE = 1'b0, CAP = 1'b1} cap_state_e;
  typedef enum logic [1:0] {RIDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} rep_state_e;

  // Capture side
  cap_state_e            cap_state_q, cap_state_d;
  logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
  logic [CORDIC_NUM-1:0] shreg_q, shreg_d;
  logic                  cap_err_q, cap_err_d;
  logic                  push_req;

  // Replay side
  rep_state_e            rep_state_q, rep_state_d;
  logic [CW-1:0]         rep_cnt_q, rep_cnt_d;
  logic                  pop_flag_q, pop_flag_d;
  logic                  pop_commit;

  // Angle FIFO
  logic [CORDIC_NUM-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push_ok;
  logic [CORDIC_NUM-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = mem_q[rptr_q];

  // Capture FSM: collect one d bit per iteration cycle; the final bit is
  // merged combinationally so the word can be pushed in its last cycle.
  always_comb begin
    cap_state_d = cap_state_q;
    cap_cnt_d   = cap_cnt_q;
    shreg_d     = shreg_q;
    cap_err_d   = cap_err_q;
    push_req    = 1'b0;
    case (cap_state_q)
      CIDLE: begin
        if (vec_start_i) begin
          cap_state_d = CAP;
          cap_cnt_d   = '0;
        end
      end
      CAP: begin
        shreg_d[cap_cnt_q] = vec_d_i;
        cap_cnt_d          = cap_cnt_q + CW'(1);
        if (vec_start_i) begin
          cap_err_d = 1'b1;
        end
        if (cap_cnt_q == LAST_IDX) begin
          push_req    = 1'b1;
          cap_state_d = CIDLE;
          cap_cnt_d   = '0;
        end
      end
      default: cap_state_d = CIDLE;
    endcase
  end

  // Replay FSM: start pulse in RIDLE, one head bit per RUN cycle, then a
  // single GAP cycle covering the rotation CORDIC's scaling cycle.
  always_comb begin
    rep_state_d = rep_state_q;
    rep_cnt_d   = rep_cnt_q;
    pop_flag_d  = pop_flag_q;
    rot_start_o = 1'b0;
    rot_d_o     = 1'b0;
    pop_commit  = 1'b0;
    case (rep_state_q)
      RIDLE: begin
        if (rot_req_i && !fifo_empty) begin
          rot_start_o = 1'b1;
          pop_flag_d  = rot_pop_i;
          rep_state_d = RUN;
          rep_cnt_d   = '0;
        end
      end
      RUN: begin
        rot_d_o   = head[rep_cnt_q];
        rep_cnt_d = rep_cnt_q + CW'(1);
        if (rep_cnt_q == LAST_IDX) begin
          rep_state_d = GAP;
          rep_cnt_d   = '0;
          pop_commit  = pop_flag_q;
        end
      end
      GAP: begin
        rep_state_d = RIDLE;
      end
      default: rep_state_d = RIDLE;
    endcase
  end

  // FIFO bookkeeping: a pop committing in the same cycle frees the slot a
  // full FIFO would otherwise refuse.
  always_comb begin
    push_ok = push_req && (!fifo_full || pop_commit);
    wptr_d  = push_ok    ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d  = pop_commit ? (rptr_q + AW'(1)) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop_commit})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || (push_req && !push_ok);
  end

  // Word storage; contents are only read while non-empty so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= shreg_d;
    end
  end

  // State registers with asynchronous reset abort any capture or replay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state_q <= CIDLE;
      cap_cnt_q   <= '0;
      shreg_q     <= '0;
      cap_err_q   <= 1'b0;
      rep_state_q <= RIDLE;
      rep_cnt_q   <= '0;
      pop_flag_q  <= 1'b0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cap_state_q <= cap_state_d;
      cap_cnt_q   <= cap_cnt_d;
      shreg_q     <= shreg_d;
      cap_err_q   <= cap_err_d;
      rep_state_q <= rep_state_d;
      rep_cnt_q   <= rep_cnt_d;
      pop_flag_q  <= pop_flag_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rot_busy_o = (rep_state_q == RUN) || (rep_state_q == GAP);
  assign empty_o    = fifo_empty;
  assign full_o     = fifo_full;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign cap_err_o  = cap_err_q;

endmodule
`default_nettype wire

// File: doc/cordic_dir_relay.md
Name: cordic_dir_relay

Overview:
- Links a vectoring-mode CORDIC to one or more rotation-mode CORDICs in the Givens/QR array.
- Captures the per-iteration direction bits (d) that the vectoring CORDIC emits, and queues each complete angle as a CORDIC_NUM-bit word.
- Replays a queued word, one bit per iteration, into a rotation-mode CORDIC, issuing that CORDIC's start pulse.
- This is the consumer/replay end of the d-bit stream; the same angle can be replayed several times before it is popped.

Parameters:
- CORDIC_NUM, 14: micro-rotations per angle; width of one angle word.
- AW, 2: FIFO address width; depth = 2**AW angle words.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- vec_start_i, input, 1: copy of the start pulse sent to the vectoring CORDIC.
- vec_d_i, input, 1: vectoring CORDIC d output, valid during its iteration cycles.
- rot_req_i, input, 1: rotation X/Y operands are ready; request a replay.
- rot_pop_i, input, 1: sampled together with an accepted rot_req_i; the head word is removed when that replay completes.
- rot_start_o, output, 1: start pulse to the rotation CORDIC.
- rot_d_o, output, 1: d input to the rotation CORDIC.
- rot_busy_o, output, 1: a replay is in progress (RUN or GAP).
- empty_o, output, 1: FIFO is empty.
- full_o, output, 1: FIFO is full.
- count_o, output, AW+1: number of stored words.
- ovf_o, output, 1: sticky flag; a captured word was dropped because the FIFO was full.
- cap_err_o, output, 1: sticky flag; vec_start_i arrived while a capture was already in progress.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, both FSMs idle, all counters 0.
  - Output values: rot_start_o=0, rot_d_o=0, rot_busy_o=0, empty_o=1, full_o=0, count_o=0, ovf_o=0, cap_err_o=0.
  - Reset asserted mid-capture or mid-replay aborts the operation; the partial word is discarded.
- CORDIC timing contract:
  - Start is sampled in cycle S.
  - Iterations i=0..CORDIC_NUM-1 occur in cycles S+1+i, with d used combinationally in each.
  - Cycle S+CORDIC_NUM+1 is the scaling cycle.
  - Cycle S+CORDIC_NUM+2 is the finish cycle, in which a new start is accepted.
- Capture FSM (CIDLE, CAP):
  - CIDLE, vec_start_i=1: go to CAP, cap_cnt=0.
  - CAP, each cycle: shreg[cap_cnt] <= vec_d_i; cap_cnt++.
  - When cap_cnt==CORDIC_NUM-1, push the completed word (including the current bit) and return to CIDLE.
  - vec_start_i in CAP: ignored; set cap_err_o.
  - A start arriving in the cycle after the last capture cycle is accepted normally.
- Push rule:
  - Push succeeds if !full, or if a pop commits in the same cycle.
  - Otherwise the word is dropped, ovf_o is set, and count is unchanged.
- Replay FSM (RIDLE, RUN, GAP):
  - RIDLE: rot_start_o = rot_req_i & !empty (combinational). When it is 1, latch rot_pop_i into pop_flag, go to RUN, rep_cnt=0.
  - RUN: rot_d_o = head[rep_cnt]; rep_cnt++. After rep_cnt==CORDIC_NUM-1, go to GAP. If pop_flag is set, the pop commits at that same edge (read pointer++, count--).
  - GAP: one cycle, covering the scaling cycle; rot_d_o=0; then go to RIDLE.
  - rot_d_o=0 outside RUN. rot_busy_o=1 in RUN and GAP. rot_start_o=0 outside RIDLE.
  - The earliest next start is CORDIC_NUM+2 cycles after the previous one, matching the finish cycle.
- Simultaneous push and pop: count unchanged; both pointers advance modulo 2**AW.
- rot_req_i while empty: no start is issued; the request is held off until a word arrives. No error is flagged.
- A word pushed in cycle T is replayable (start issued) from cycle T+1.

Test Plan:
- Capture then replay: vec_start_i, then d bits (i=0 first) 1,1,0,0,0,1,1,1,0,0,1,1,0,1 → count_o=1 after 15 cycles. Then rot_req_i=1, rot_pop_i=1 → rot_start_o=1 in one cycle; rot_d_o replays the identical 14 bits over the next 14 cycles; then count_o=0, empty_o=1.
- Multi-replay: one word, three requests with rot_pop_i=0,0,1 → three identical bit streams; starts are spaced exactly 16 cycles apart; the word is removed only after the third replay.
- Full/overflow: five back-to-back captures (vec_start_i every 16 cycles) with no requests → full_o=1 and count_o=4 after the fourth; the fifth sets ovf_o=1 and the FIFO contents are unchanged. Replay order is oldest first.
- Simultaneous push/pop at full: at the edge where a replay with pop commits, a capture completes → count_o stays 4 and ovf_o stays 0.
- Capture error: vec_start_i asserted again at capture bit 5 → cap_err_o=1; the word still completes at its original 14th bit with the original bits.
- Async reset mid-RUN at rep_cnt=7 → rot_busy_o=0, rot_d_o=0, empty_o=1 immediately. After release, a request with the FIFO empty produces no rot_start_o.
